// File: rtl/spi_master_shifter.sv
// SPI mode-0, MSB-first shift engine driven by the divider tick.
// One word per frame on a valid/ready handshake; received word strobed out.
module spi_master_shifter #(
   parameter int DATA_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  spi_clk_en,
   input  logic [DATA_WIDTH-1:0] tx_data,
   input  logic                  tx_valid,
   output logic                  tx_ready,
   output logic [DATA_WIDTH-1:0] rx_data,
   output logic                  rx_valid,
   output logic                  busy,
   output logic                  sclk,
   output logic                  mosi,
   input  logic                  miso,
   output logic                  cs_n
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      SHIFT,
      HOLD
   } state_t;

   state_t                state, state_nx;
   logic [DATA_WIDTH-1:0] tx_sr, tx_sr_nx;
   logic [DATA_WIDTH-1:0] rx_sr, rx_sr_nx;
   logic [DATA_WIDTH-1:0] rx_data_nx;
   logic [CW-1:0]         bit_cnt, bit_cnt_nx;
   logic                  sclk_nx, mosi_nx, cs_n_nx, rx_valid_nx;

   assign tx_ready = (state == IDLE) & ~rst;
   assign busy     = (state != IDLE);

   always_comb begin
      state_nx    = state;
      tx_sr_nx    = tx_sr;
      rx_sr_nx    = rx_sr;
      rx_data_nx  = rx_data;
      bit_cnt_nx  = bit_cnt;
      sclk_nx     = sclk;
      mosi_nx     = mosi;
      cs_n_nx     = cs_n;
      rx_valid_nx = 1'b0;
      unique case (state)
         IDLE: begin
            if (tx_valid && tx_ready) begin
               tx_sr_nx   = tx_data;
               mosi_nx    = tx_data[DATA_WIDTH-1];
               cs_n_nx    = 1'b0;
               bit_cnt_nx = '0;
               state_nx   = SETUP;
            end
         end
         SETUP: begin
            if (spi_clk_en) state_nx = SHIFT;
         end
         SHIFT: begin
            if (spi_clk_en) begin
               sclk_nx = ~sclk;
               // rising tick samples MISO, falling tick advances MOSI
               if (!sclk) begin
                  rx_sr_nx = {rx_sr[DATA_WIDTH-2:0], miso};
               end else if (bit_cnt == LAST) begin
                  state_nx = HOLD;
               end else begin
                  tx_sr_nx   = tx_sr << 1;
                  mosi_nx    = tx_sr[DATA_WIDTH-2];
                  bit_cnt_nx = bit_cnt + 1'b1;
               end
            end
         end
         HOLD: begin
            if (spi_clk_en) begin
               cs_n_nx     = 1'b1;
               mosi_nx     = 1'b0;
               rx_data_nx  = rx_sr;
               rx_valid_nx = 1'b1;
               state_nx    = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx_sr    <= '0;
         rx_sr    <= '0;
         rx_data  <= '0;
         bit_cnt  <= '0;
         sclk     <= 1'b0;
         mosi     <= 1'b0;
         cs_n     <= 1'b1;
         rx_valid <= 1'b0;
      end else begin
         state    <= state_nx;
         tx_sr    <= tx_sr_nx;
         rx_sr    <= rx_sr_nx;
         rx_data  <= rx_data_nx;
         bit_cnt  <= bit_cnt_nx;
         sclk     <= sclk_nx;
         mosi     <= mosi_nx;
         cs_n     <= cs_n_nx;
         rx_valid <= rx_valid_nx;
      end
   end

endmodule

// File: tb/tb_spi_master_shifter.sv
// Bench for spi_master_shifter: directed frames, scoreboard queue,
// negedge monitor checking every received word and frame shape.
module tb_spi_master_shifter;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       spi_clk_en;
   logic [7:0] tx_data = 8'h00;
   logic       tx_valid = 1'b0;
   logic       tx_ready;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       busy;
   logic       sclk;
   logic       mosi;
   logic       miso;
   logic       cs_n;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [7:0] tx;
      logic [7:0] rx;
      int         cyc;
   } exp_t;
   exp_t sb[$];

   logic       gen_tick = 1'b0;
   logic       force_tick = 1'b0;
   int         period = 0;
   int         tcnt = 0;
   logic       loop = 1'b1;
   logic [7:0] slave_word = 8'h00;
   logic [7:0] slave_bits;

   int         rises = 0;
   int         ticks = 0;
   int         cyc = 0;
   logic       in_frame = 1'b0;
   logic       cs_bad = 1'b0;
   logic       rdy_bad = 1'b0;
   logic [7:0] mosi_cap = 8'h00;
   logic       sclk_prev = 1'b0;
   logic       rxv_prev = 1'b0;

   assign spi_clk_en = gen_tick | force_tick;
   assign slave_bits = slave_word << rises;
   assign miso = loop ? mosi : slave_bits[7];

   spi_master_shifter #(.DATA_WIDTH(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .spi_clk_en(spi_clk_en),
      .tx_data   (tx_data),
      .tx_valid  (tx_valid),
      .tx_ready  (tx_ready),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .busy      (busy),
      .sclk      (sclk),
      .mosi      (mosi),
      .miso      (miso),
      .cs_n      (cs_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
      end
   endtask

   // divider model: one tick every 'period' clocks, 0 = stopped
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (period == 0) begin
            gen_tick = 1'b0;
            tcnt     = 0;
         end else begin
            gen_tick = (tcnt == 0);
            tcnt     = (tcnt + 1 >= period) ? 0 : tcnt + 1;
         end
      end
   end

   // monitor: outputs checked first, then events due at the next edge
   always @(negedge clk) begin
      if (rst) begin
         in_frame = 1'b0;
      end else begin
         if (rx_valid) begin
            chk("rx_valid_pulse", 32'(rxv_prev), 32'd0);
            if (sb.size() == 0) begin
               chk("unexpected_rx_valid", 32'd1, 32'd0);
            end else begin
               exp_t e;
               e = sb.pop_front();
               chk("rx_data", 32'(rx_data), 32'(e.rx));
               chk("mosi_bits", 32'(mosi_cap), 32'(e.tx));
               chk("sclk_rises", 32'(rises), 32'd8);
               chk("frame_ticks", 32'(ticks), 32'd18);
               chk("sclk_end_low", 32'(sclk), 32'd0);
               chk("cs_n_end_high", 32'(cs_n), 32'd1);
               chk("cs_n_low_in_frame", 32'(cs_bad), 32'd0);
               chk("tx_ready_low_in_frame", 32'(rdy_bad), 32'd0);
               if (e.cyc != 0) chk("frame_clks", 32'(cyc), 32'(e.cyc));
            end
         end
         if (sclk && !sclk_prev) begin
            rises++;
            mosi_cap = {mosi_cap[6:0], mosi};
         end
         if (in_frame) begin
            if (cs_n) cs_bad = 1'b1;
            if (tx_ready) rdy_bad = 1'b1;
         end
         if (tx_valid && tx_ready) begin
            in_frame = 1'b1;
            ticks    = 0;
            cyc      = 0;
            rises    = 0;
            cs_bad   = 1'b0;
            rdy_bad  = 1'b0;
         end else if (in_frame) begin
            cyc++;
            if (spi_clk_en) begin
               ticks++;
               if (ticks == 18) in_frame = 1'b0;
            end
         end
      end
      sclk_prev = sclk;
      rxv_prev  = rx_valid;
   end

   // junk on tx_data every cycle until accepted; expected pushed on accept
   task automatic send(input logic [7:0] w, input logic [7:0] r,
                       input int clks, input bit ft, input bit keep);
      int n = 0;
      @(posedge clk);
      #1;
      tx_valid = 1'b1;
      while (!tx_ready && n < 1000) begin
         tx_data = 8'($urandom);
         n++;
         @(posedge clk);
         #1;
      end
      if (!tx_ready) begin
         chk("accept_timeout", 32'd1, 32'd0);
         tx_valid = 1'b0;
         return;
      end
      tx_data    = w;
      force_tick = ft;
      sb.push_back('{w, r, clks});
      @(posedge clk);
      #1;
      force_tick = 1'b0;
      tx_valid   = keep;
      tx_data    = 8'($urandom);
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while ((sb.size() != 0 || busy) && n < 2000);
      if (sb.size() != 0 || busy) begin
         chk("frame_timeout", 32'd1, 32'd0);
         sb.delete();
      end
   endtask

   task automatic wait_rises(input int k);
      int n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (rises < k && n < 500);
      if (rises < k) chk("rise_timeout", 32'(rises), 32'(k));
   endtask

   logic s_sclk, s_mosi, s_cs_n;

   initial begin
      period = 4;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_cs_n", 32'(cs_n), 32'd1);
      chk("rst_sclk", 32'(sclk), 32'd0);
      chk("rst_mosi", 32'(mosi), 32'd0);
      chk("rst_rx_data", 32'(rx_data), 32'd0);
      chk("rst_rx_valid", 32'(rx_valid), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_tx_ready", 32'(tx_ready), 32'd0);
      rst = 1'b0;
      #1;
      chk("idle_tx_ready", 32'(tx_ready), 32'd1);

      // loopback, tick every 4 clk
      loop = 1'b1;
      send(8'hA5, 8'hA5, 0, 1'b0, 1'b0);
      wait_idle();

      // slave returns 0x3C while 0xC3 goes out
      loop       = 1'b0;
      slave_word = 8'h3C;
      send(8'hC3, 8'h3C, 0, 1'b0, 1'b0);
      wait_idle();
      loop = 1'b1;

      // tx_valid held, data churning; back-to-back frames
      send(8'h01, 8'h01, 0, 1'b0, 1'b1);
      send(8'h80, 8'h80, 0, 1'b0, 1'b0);
      wait_idle();

      // reset after the third sclk rise abandons the frame
      send(8'h77, 8'h77, 0, 1'b0, 1'b0);
      wait_rises(3);
      rst = 1'b1;
      @(posedge clk);
      #1;
      sb.delete();
      chk("midrst_cs_n", 32'(cs_n), 32'd1);
      chk("midrst_sclk", 32'(sclk), 32'd0);
      chk("midrst_mosi", 32'(mosi), 32'd0);
      chk("midrst_rx_data", 32'(rx_data), 32'd0);
      chk("midrst_rx_valid", 32'(rx_valid), 32'd0);
      rst = 1'b0;
      send(8'h5A, 8'h5A, 0, 1'b0, 1'b0);
      wait_idle();

      // tick in the accept cycle must be ignored
      send(8'h96, 8'h96, 0, 1'b1, 1'b0);
      wait_idle();

      // ticks stop mid-SHIFT: outputs freeze, then resume
      send(8'h3E, 8'h3E, 0, 1'b0, 1'b0);
      wait_rises(4);
      period = 0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      s_sclk = sclk;
      s_mosi = mosi;
      s_cs_n = cs_n;
      repeat (20) @(posedge clk);
      #1;
      chk("freeze_sclk", 32'(sclk), 32'(s_sclk));
      chk("freeze_mosi", 32'(mosi), 32'(s_mosi));
      chk("freeze_cs_n", 32'(cs_n), 32'(s_cs_n));
      chk("freeze_busy", 32'(busy), 32'd1);
      period = 3;
      wait_idle();

      // continuous ticks: 18 clk per frame
      period = 1;
      repeat (2) @(posedge clk);
      send(8'hFF, 8'hFF, 18, 1'b0, 1'b0);
      wait_idle();
      send(8'h00, 8'h00, 18, 1'b0, 1'b0);
      wait_idle();

      repeat (10) @(posedge clk);
      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
